// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of an asynchronous FIFO.
// Brings the Gray-coded write pointer into the read clock domain through a
// flop chain. Keeps the binary and Gray read pointers, and registers the
// empty flag and the occupancy seen from the read side.
module fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_gray_async,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W:0]   rd_count
);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of Gray bits ADDR_W down to i.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][ADDR_W:0] r_wq;
  logic [ADDR_W:0]                  r_rbin;
  logic [ADDR_W:0]                  r_rptr_gray;
  logic [ADDR_W:0]                  r_count;
  logic                             r_empty;

  logic [ADDR_W:0]                  w_wq;
  logic [ADDR_W:0]                  w_wbin;
  logic                             w_pop;
  logic [ADDR_W:0]                  w_rbin_next;

  // Synchronizer: plain flop chain, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wq <= '0;
    end else begin
      r_wq[0] <= wptr_gray_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_wq[s] <= r_wq[s-1];
      end
    end
  end

  assign w_wq   = r_wq[SYNC_STAGES-1];
  assign w_wbin = gray2bin(w_wq);

  // A ready held while the FIFO is empty never advances the pointer.
  assign w_pop       = ~r_empty & rd_ready;
  assign w_rbin_next = r_rbin + {{ADDR_W{1'b0}}, w_pop};

  // Read pointer, Gray copy, empty flag and occupancy all update from rbin_next
  // on the same edge. A pop and a newly arrived write pointer are therefore
  // both accounted for in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rptr_gray <= bin2gray(w_rbin_next);
      r_count     <= w_wbin - w_rbin_next;
      r_empty     <= (bin2gray(w_rbin_next) == w_wq);
    end
  end

  assign rd_valid  = ~r_empty;
  assign raddr     = r_rbin[ADDR_W-1:0];
  assign rptr_gray = r_rptr_gray;
  assign rd_count  = r_count;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl (ADDR_W=4, SYNC_STAGES=2). Every write the bench
// makes pushes the RAM address of each new entry onto a scoreboard queue.
// A monitor pops the queue on each accepted read and checks raddr. It also
// checks that rptr_gray moves by a single bit at a time.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] wptr_gray_async;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic [4:0] rd_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wbin     = 0;
  int         rcnt     = 0;
  logic [3:0] sb[$];
  logic [3:0] mon_exp;
  logic [4:0] prev_gray = '0;
  bit         saw_wrap  = 0;

  fifo_rd_ctrl #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wptr_gray_async(wptr_gray_async),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .raddr          (raddr),
    .rptr_gray      (rptr_gray),
    .rd_count       (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inputs and outputs are stable at the falling edge. A read seen here is
  // accepted at the next rising edge, unless reset intervenes; reset is only
  // ever raised after the falling edge has been seen.
  always @(negedge clk) begin
    if (rst) begin
      prev_gray = '0;
    end else begin
      if (rptr_gray !== prev_gray) begin
        n_checks++;
        if ($countones(rptr_gray ^ prev_gray) != 1) begin
          n_fail++;
          $display("FAIL gray_step: rptr_gray %b -> %b, required a one-bit change", prev_gray, rptr_gray);
        end
        if (prev_gray == 5'b10000 && rptr_gray == 5'b00000) saw_wrap = 1;
        prev_gray = rptr_gray;
      end
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: read accepted at raddr=%0d, required no read (nothing written)", raddr);
        end else begin
          mon_exp = sb.pop_front();
          if (raddr !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_raddr: got %0d, required %0d", raddr, mon_exp);
          end
        end
        rcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the write pointer to nb and record the addresses of the new entries.
  task automatic set_wbin(input int nb);
    for (int a = wbin; a < nb; a++) sb.push_back(4'(a % 16));
    wbin = nb;
    wptr_gray_async = g5(5'(wbin % 32));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rd_ready = 1'b0;
    wbin = 0;
    wptr_gray_async = '0;
    sb.delete();
    rcnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_ready = 1'b0;
    wptr_gray_async = '0;
    #1;
    n_checks += 4;
    if (rd_valid  !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b, required 0", rd_valid); end
    if (raddr     !== 4'd0) begin n_fail++; $display("FAIL rst_async_raddr: got %0d, required 0", raddr); end
    if (rptr_gray !== 5'd0) begin n_fail++; $display("FAIL rst_async_rptr: got %b, required 00000", rptr_gray); end
    if (rd_count  !== 5'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d, required 0", rd_count); end
    tick();
    tick();
    rst = 1'b0;
    rd_ready = 1'b1;
    repeat (5) tick();
    n_checks += 4;
    if (rd_valid  !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b, required 0", rd_valid); end
    if (raddr     !== 4'd0) begin n_fail++; $display("FAIL idle_raddr: got %0d, required 0", raddr); end
    if (rptr_gray !== 5'd0) begin n_fail++; $display("FAIL idle_rptr: got %b, required 00000", rptr_gray); end
    if (rd_count  !== 5'd0) begin n_fail++; $display("FAIL idle_count: got %0d, required 0", rd_count); end
    rd_ready = 1'b0;
  endtask

  task automatic test_single();
    set_wbin(1);
    tick();
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: rd_valid %b after edge 2, required 0", rd_valid); end
    tick();
    n_checks += 2;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, required 1", rd_valid); end
    if (rd_count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d, required 1", rd_count); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks += 4;
    if (raddr     !== 4'd1)     begin n_fail++; $display("FAIL single_raddr: got %0d, required 1", raddr); end
    if (rptr_gray !== 5'b00001) begin n_fail++; $display("FAIL single_rptr: got %b, required 00001", rptr_gray); end
    if (rd_valid  !== 1'b0)     begin n_fail++; $display("FAIL single_empty: got %b, required 0", rd_valid); end
    if (rd_count  !== 5'd0)     begin n_fail++; $display("FAIL single_count0: got %0d, required 0", rd_count); end
  endtask

  task automatic test_full();
    apply_reset();
    set_wbin(16);
    repeat (3) tick();
    n_checks += 2;
    if (rd_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d, required 16", rd_count); end
    if (rd_valid !== 1'b1)  begin n_fail++; $display("FAIL full_valid: got %b, required 1", rd_valid); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (rd_count !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL full_drain_count: pop %0d got %0d, required %0d", i, rd_count, 15 - i);
      end
    end
    rd_ready = 1'b0;
    n_checks += 4;
    if (rd_valid  !== 1'b0)     begin n_fail++; $display("FAIL full_empty: got %b, required 0", rd_valid); end
    if (rptr_gray !== 5'b11000) begin n_fail++; $display("FAIL full_rptr: got %b, required 11000", rptr_gray); end
    if (raddr     !== 4'd0)     begin n_fail++; $display("FAIL full_raddr: got %0d, required 0", raddr); end
    if (sb.size() != 0)         begin n_fail++; $display("FAIL full_sb_left: %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    saw_wrap = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_wbin(wbin + 1);
      tick();
      n_checks++;
      if (rd_count > 5'd16) begin n_fail++; $display("FAIL wrap_count_bound: got %0d, required <= 16", rd_count); end
    end
    for (int t = 0; t < 50 && rd_valid === 1'b1; t++) tick();
    rd_ready = 1'b0;
    n_checks += 5;
    if (rd_valid  !== 1'b0)     begin n_fail++; $display("FAIL wrap_drain_timeout: rd_valid %b, required 0", rd_valid); end
    if (saw_wrap  !== 1'b1)     begin n_fail++; $display("FAIL wrap_seen: got %b, required 1", saw_wrap); end
    if (rptr_gray !== 5'b11000) begin n_fail++; $display("FAIL wrap_rptr: got %b, required 11000", rptr_gray); end
    if (rd_count  !== 5'd0)     begin n_fail++; $display("FAIL wrap_count: got %0d, required 0", rd_count); end
    if (sb.size() != 0)         begin n_fail++; $display("FAIL wrap_sb_left: %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_wbin(1);
    repeat (3) tick();
    n_checks++;
    if (rd_count !== 5'd1) begin n_fail++; $display("FAIL b2b_count1: got %0d, required 1", rd_count); end
    rd_ready = 1'b1;
    set_wbin(2);
    tick();
    rd_ready = 1'b0;
    set_wbin(3);
    tick();
    tick();
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b, required 1", rd_valid); end
    tick();
    n_checks += 2;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b, required 1", rd_valid); end
    if (rd_count !== 5'd2) begin n_fail++; $display("FAIL b2b_count2: got %0d, required 2", rd_count); end
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    n_checks += 2;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b, required 0", rd_valid); end
    if (sb.size() != 0)    begin n_fail++; $display("FAIL b2b_sb_left: %0d entries, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_wbin(8);
    repeat (3) tick();
    n_checks++;
    if (rd_count !== 5'd8) begin n_fail++; $display("FAIL mid_count8: got %0d, required 8", rd_count); end
    rd_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (rd_valid  !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, required 0", rd_valid); end
    if (raddr     !== 4'd0) begin n_fail++; $display("FAIL mid_rst_raddr: got %0d, required 0", raddr); end
    if (rptr_gray !== 5'd0) begin n_fail++; $display("FAIL mid_rst_rptr: got %b, required 00000", rptr_gray); end
    if (rd_count  !== 5'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d, required 0", rd_count); end
    tick();
    rd_ready = 1'b0;
    sb.delete();
    rcnt = 0;
    tick();
    rst = 1'b0;
    n_checks++;
    if (rptr_gray !== 5'd0) begin n_fail++; $display("FAIL mid_no_pop: rptr_gray %b, required 00000", rptr_gray); end
    wbin = 0;
    set_wbin(8);
    tick();
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_resync_early: got %b, required 0", rd_valid); end
    tick();
    n_checks += 2;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_resync_valid: got %b, required 1", rd_valid); end
    if (rd_count !== 5'd8) begin n_fail++; $display("FAIL mid_resync_count: got %0d, required 8", rd_count); end
    rd_ready = 1'b1;
    repeat (8) tick();
    rd_ready = 1'b0;
    n_checks += 2;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drain_empty: got %b, required 0", rd_valid); end
    if (sb.size() != 0)    begin n_fail++; $display("FAIL mid_sb_left: %0d entries, required 0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: FIFO address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops for the incoming write pointer; legal values >= 2.
REQ-003 SHALL have port clk  input  1: read-domain clock; all state is rising-edge clocked.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port wptr_gray_async  input  ADDR_W+1: write pointer in Gray code, launched from the write clock domain and asynchronous to clk.
REQ-006 SHALL have port rd_ready  input  1: consumer accepts the entry at raddr this cycle.
REQ-007 SHALL have port rd_valid  output  1: FIFO non-empty; the entry at raddr is readable.
REQ-008 SHALL have port raddr  output  ADDR_W: RAM read address, equal to the low ADDR_W bits of the binary read pointer.
REQ-009 SHALL have port rptr_gray  output  ADDR_W+1: registered Gray read pointer, sent to the write domain.
REQ-010 SHALL have port rd_count  output  ADDR_W+1: registered occupancy, as seen from the read domain.

Function
REQ-011 SHALL pass wptr_gray_async through a SYNC_STAGES-deep flop chain (wq) with no combinational logic before or between stages.
REQ-012 SHALL convert wq to binary (wbin): bit i = XOR of wq[ADDR_W:i].
REQ-013 SHALL define pop = rd_valid AND rd_ready; rd_ready while rd_valid=0 SHALL be ignored.
REQ-014 SHALL keep a binary read pointer rbin (ADDR_W+1 bits); rbin_next = rbin + pop, wrapping modulo 2^(ADDR_W+1).
REQ-015 SHALL register rptr_gray <= rbin_next XOR (rbin_next >> 1) in the same edge as rbin <= rbin_next.
REQ-016 raddr SHALL be the low ADDR_W bits of registered rbin; raddr never depends combinationally on rd_ready.
REQ-017 SHALL register empty <= (bin2gray(rbin_next) == wq); rd_valid = NOT empty.
REQ-018 SHALL register rd_count <= (wbin - rbin_next) modulo 2^(ADDR_W+1).
REQ-019 Latency: a change on wptr_gray_async stable before edge k SHALL be reflected in rd_valid/rd_count after edge k+SYNC_STAGES.
REQ-020 Pop of the last entry SHALL deassert rd_valid on the next edge, with no extra read.
REQ-021 Pop and write-pointer arrival in the same cycle SHALL both be accounted for; rd_valid stays high if new data is present.
REQ-022 rptr_gray SHALL change by at most one bit per clk edge, including at the 2^(ADDR_W+1)-1 -> 0 wrap.
REQ-023 With legal input (wptr - rptr <= 2^ADDR_W), rd_count SHALL never exceed 2^ADDR_W.

Reset
REQ-024 During rst SHALL force all synchronizer stages, rbin, rptr_gray, rd_count = 0, empty = 1, rd_valid = 0, raddr = 0, with no clock required.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight pop and synchronizer contents; the first pop is possible at the earliest SYNC_STAGES+1 edges after rst deasserts with a nonzero wptr.

Verification (ADDR_W=4, SYNC_STAGES=2)
REQ-026 Pulse rst -> rd_valid=0, raddr=0, rptr_gray=5'b00000, rd_count=0; hold rd_ready=1 with wptr=0 -> all outputs unchanged.
REQ-027 wptr_gray_async=5'b00001 before edge 1 -> rd_valid=1 and rd_count=1 after edge 3; rd_ready=1 for one cycle -> raddr=1, rptr_gray=5'b00001, rd_valid=0, rd_count=0.
REQ-028 Full case: wptr_gray_async=5'b11000 (bin 16) -> rd_count=16; continuous rd_ready -> raddr 0..15, rd_valid=0 after the 16th pop, rptr_gray=5'b11000.
REQ-029 Wrap case: advance wptr and pops through 32 entries -> raddr wraps 15->0, rptr_gray returns 5'b10000 -> 5'b00000, one bit flip per step (checker on every edge).
REQ-030 Simultaneous case: rd_count=1, pop in the same cycle that wptr advances to 2 entries beyond -> no empty glitch beyond sync latency, final rd_count=2.
REQ-031 Assert rst mid-burst with rd_count=8 -> outputs at reset values immediately (asynchronous), no pop counted.
